// File: rtl/rom_burst_reader.sv
// -----------------------------------------------------------------------------
// rom_burst_reader
//   Synchronous ROM with a burst-read engine. A start pulse accepted while idle
//   fetches burst_len+1 consecutive words beginning at start_addr. The address
//   wraps from DEPTH-1 to 0. Words leave on a valid/ready interface at one word
//   per cycle whenever the consumer is not stalling.
//
// Parameters
//   WIDTH      data word width in bits (>=1)
//   DEPTH      number of words, power of two, >=2
//   INIT_FILE  image name; contents come from the built-in table
//   AW         address width, derived from DEPTH (not overridable)
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   start       burst request, ignored while busy
//   start_addr  first word address, sampled on an accepted start
//   burst_len   number of words in the burst minus one
//   busy        burst in progress
//   data_out    current word, held while data_valid && !data_ready
//   data_valid  data_out carries a valid word
//   data_ready  consumer accepts the word when data_valid is also high
//   last        marks the final word of the burst
//   parity      even parity of data_out (only with ROM_PARITY_EN defined)
//
// Build option
//   ROM_PARITY_EN  adds the registered parity output.
// -----------------------------------------------------------------------------
module rom_burst_reader #(
  parameter int    WIDTH     = 8,
  parameter int    DEPTH     = 16,
  parameter string INIT_FILE = "",
  localparam int   AW        = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [AW-1:0]    start_addr,
  input  logic [AW-1:0]    burst_len,
  output logic             busy,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             last
`ifdef ROM_PARITY_EN
  ,
  output logic             parity
`endif
);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  // Built-in contents: a 16-entry byte table repeated across the array,
  // zero-extended above bit 7 or truncated to the LSBs for narrow words.
  function automatic logic [WIDTH-1:0] default_word(input int i);
    logic [7:0] b;
    case (i % 16)
      0:       b = 8'h5d;
      1:       b = 8'h7a;
      2:       b = 8'hcd;
      3:       b = 8'h6e;
      4:       b = 8'hab;
      5:       b = 8'h9d;
      6:       b = 8'h87;
      7:       b = 8'h7f;
      8:       b = 8'hce;
      9:       b = 8'h51;
      10:      b = 8'hef;
      11:      b = 8'h8a;
      12:      b = 8'h9b;
      13:      b = 8'h1f;
      14:      b = 8'h2b;
      default: b = 8'h5d;
    endcase
    return WIDTH'(b);
  endfunction

`ifdef ROM_PARITY_EN
  function automatic logic even_parity(input logic [WIDTH-1:0] w);
    return ^w;
  endfunction
`endif

  logic [WIDTH-1:0] rom [DEPTH];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      rom[i] = default_word(i);
    end
  end

  state_t           state, state_nxt;
  logic [AW-1:0]    addr_p0, addr_nxt;
  logic [AW-1:0]    rem_p0, rem_nxt;
  logic [WIDTH-1:0] data_p1, data_nxt;
  logic             vld_p1, vld_nxt;
  logic             last_p1, last_nxt;
  logic [AW-1:0]    addr_inc;

  assign addr_inc = addr_p0 + AW'(1);

  // addr_p0 always points at the word currently presented on data_out, so a
  // transfer fetches addr_p0+1 and the next word is ready without a bubble.
  always_comb begin
    state_nxt = state;
    addr_nxt  = addr_p0;
    rem_nxt   = rem_p0;
    data_nxt  = data_p1;
    vld_nxt   = vld_p1;
    last_nxt  = last_p1;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = STREAM;
          addr_nxt  = start_addr;
          rem_nxt   = burst_len;
          data_nxt  = rom[start_addr];
          vld_nxt   = 1'b1;
          last_nxt  = (burst_len == '0);
        end
      end
      STREAM: begin
        if (vld_p1 && data_ready) begin
          if (rem_p0 == '0) begin
            state_nxt = IDLE;
            vld_nxt   = 1'b0;
            last_nxt  = 1'b0;
          end else begin
            addr_nxt = addr_inc;
            rem_nxt  = rem_p0 - AW'(1);
            data_nxt = rom[addr_inc];
            last_nxt = (rem_p0 == AW'(1));
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        vld_nxt   = 1'b0;
        last_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---- stage p0: burst address / remaining-count registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_p0 <= '0;
      rem_p0  <= '0;
    end else begin
      addr_p0 <= addr_nxt;
      rem_p0  <= rem_nxt;
    end
  end

  // ---- stage p1: registered ROM word and its qualifiers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_p1 <= '0;
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end else begin
      data_p1 <= data_nxt;
      vld_p1  <= vld_nxt;
      last_p1 <= last_nxt;
    end
  end

`ifdef ROM_PARITY_EN
  logic par_p1;

  // Follows data_nxt, so it holds exactly when data_out holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_p1 <= 1'b0;
    end else begin
      par_p1 <= even_parity(data_nxt);
    end
  end

  assign parity = par_p1;
`endif

  assign busy       = (state == STREAM);
  assign data_out   = data_p1;
  assign data_valid = vld_p1;
  assign last       = last_p1;

endmodule

// File: tb/tb_rom_burst_reader.sv
module tb_rom_burst_reader;
  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [AW-1:0]    start_addr = '0;
  logic [AW-1:0]    burst_len = '0;
  logic             data_ready = 1'b1;
  logic             busy;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             last;
`ifdef ROM_PARITY_EN
  logic             parity;
`endif

  int checks = 0;
  int failures = 0;

  logic [7:0] tbl [16] = '{8'h5d, 8'h7a, 8'hcd, 8'h6e, 8'hab, 8'h9d, 8'h87, 8'h7f,
                           8'hce, 8'h51, 8'hef, 8'h8a, 8'h9b, 8'h1f, 8'h2b, 8'h5d};

  rom_burst_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .INIT_FILE("")) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_addr (start_addr),
    .burst_len  (burst_len),
    .busy       (busy),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .last       (last)
`ifdef ROM_PARITY_EN
    ,
    .parity     (parity)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: a burst is the list T[(a+k) mod 16], k=0..len. The consumer
  // pops the head whenever it asserted ready at an edge where valid was high.
  task automatic burst(input logic [3:0] a, input logic [3:0] len, input int stall,
                       input bit rnd_ready, input bit spurious);
    logic [7:0] q[$];
    int cyc;
    bit rdy;
    for (int k = 0; k <= int'(len); k++) q.push_back(tbl[(int'(a) + k) % 16]);
    check("idle_before_start", {31'd0, busy}, 32'd0);
    start      = 1'b1;
    start_addr = a;
    burst_len  = len;
    tick();
    start      = 1'b0;
    start_addr = 4'($urandom);
    burst_len  = 4'($urandom);
    check("busy_after_start", {31'd0, busy}, 32'd1);
    cyc = 0;
    while (q.size() > 0 && cyc < 200) begin
      check("valid", {31'd0, data_valid}, 32'd1);
      check("data", {24'd0, data_out}, {24'd0, q[0]});
      check("last", {31'd0, last}, {31'd0, q.size() == 1});
`ifdef ROM_PARITY_EN
      check("parity", {31'd0, parity}, {31'd0, ^q[0]});
`endif
      if (cyc < stall) rdy = 1'b0;
      else if (rnd_ready) rdy = 1'($urandom_range(0, 1));
      else rdy = 1'b1;
      data_ready = rdy;
      start      = spurious;
      tick();
      cyc++;
      if (rdy) void'(q.pop_front());
    end
    start      = 1'b0;
    data_ready = 1'b1;
    check("burst_drained", q.size(), 32'd0);
    check("busy_end", {31'd0, busy}, 32'd0);
    check("valid_end", {31'd0, data_valid}, 32'd0);
    check("last_end", {31'd0, last}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_valid", {31'd0, data_valid}, 32'd0);
    check("rst_last", {31'd0, last}, 32'd0);
    check("rst_data", {24'd0, data_out}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Directed bursts
    burst(4'h0, 4'd3, 0, 1'b0, 1'b0);   // 5d 7a cd 6e
    burst(4'hE, 4'd2, 0, 1'b0, 1'b0);   // wrap: 2b 5d 5d
    burst(4'h4, 4'd1, 3, 1'b0, 1'b0);   // backpressure on ab
    burst(4'h8, 4'd1, 0, 1'b0, 1'b1);   // spurious starts ignored: ce 51
    burst(4'h2, 4'd1, 0, 1'b0, 1'b0);   // accepted on first idle cycle: cd 6e
    burst(4'h9, 4'd0, 0, 1'b0, 1'b0);   // single word 51
    burst(4'h5, 4'd15, 0, 1'b0, 1'b0);  // full-depth with wrap
    burst(4'h0, 4'd15, 2, 1'b1, 1'b1);

    // Randomized bursts
    for (int n = 0; n < 40; n++) begin
      burst(4'($urandom), 4'($urandom), int'($urandom_range(0, 2)),
            1'b1, 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset in the middle of a burst
    start      = 1'b1;
    start_addr = 4'h3;
    burst_len  = 4'd10;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("pre_rst_valid", {31'd0, data_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    check("async_rst_valid", {31'd0, data_valid}, 32'd0);
    check("async_rst_last", {31'd0, last}, 32'd0);
    check("async_rst_data", {24'd0, data_out}, 32'd0);
`ifdef ROM_PARITY_EN
    check("async_rst_parity", {31'd0, parity}, 32'd0);
`endif
    tick();
    check("rst_hold_valid", {31'd0, data_valid}, 32'd0);
    rst_n = 1'b1;
    tick();
    check("post_rst_idle_valid", {31'd0, data_valid}, 32'd0);
    burst(4'hD, 4'd4, 1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
